// File: rtl/adaptive_threshold_pkg.sv
// Shared project constants for the image pipeline: global_state phase codes,
// the thresholding FSM encoding and the binary pixel values.
package adaptive_threshold_pkg;

    // Pipeline phases broadcast on global_state; thresholding runs in phase 2.
    localparam logic [2:0] GS_INIT       = 3'd0;
    localparam logic [2:0] GS_BOX_FILTER = 3'd1;
    localparam logic [2:0] GS_THRESHOLD  = 3'd2;
    localparam logic [2:0] GS_FINISHED   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } at_state_t;

    localparam logic [7:0] PIX_WHITE = 8'd255;
    localparam logic [7:0] PIX_BLACK = 8'd0;

endpackage

// File: rtl/adaptive_threshold_if.sv
// Memory-side bus of the thresholder: source image read port, mean image
// read port and binary result write port.
interface adaptive_threshold_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [7:0]             iImageData;
    logic [WIDTH_BITS-1:0]  oMeanCol;
    logic [HEIGHT_BITS-1:0] oMeanRow;
    logic [7:0]             iMeanData;
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [7:0]             oResultData;
    logic                   oResultWren;

    // The thresholder drives addresses and write data.
    modport master (
        output oImageCol, oImageRow, input iImageData,
        output oMeanCol, oMeanRow, input iMeanData,
        output oResultCol, oResultRow, oResultData, oResultWren
    );

    // The memories answer reads and accept writes.
    modport slave (
        input oImageCol, oImageRow, output iImageData,
        input oMeanCol, oMeanRow, output iMeanData,
        input oResultCol, oResultRow, oResultData, oResultWren
    );
endinterface

// File: rtl/adaptive_threshold_threshold_cmp.sv
// Binarise one pixel against its local mean: white iff pixel > mean - offset.
module threshold_cmp
    import adaptive_threshold_pkg::*;
(
    input  logic [7:0] i_pixel,
    input  logic [7:0] i_mean,
    input  logic [7:0] i_offset,
    output logic [7:0] o_result
);
    // 10-bit signed keeps mean - offset exact down to -255, so a dark mean
    // produces a negative threshold that every pixel exceeds.
    logic signed [9:0] w_threshold;
    logic signed [9:0] w_pixel;

    assign w_threshold = $signed({2'b00, i_mean}) - $signed({2'b00, i_offset});
    assign w_pixel     = $signed({2'b00, i_pixel});
    assign o_result    = (w_pixel > w_threshold) ? PIX_WHITE : PIX_BLACK;
endmodule

// File: rtl/adaptive_threshold.sv
// Adaptive thresholding stage: streams pixels START_POS..END_POS from the
// source and mean memories (1-cycle synchronous read) and writes a binary
// image one pixel per cycle while global_state selects this phase.
module adaptive_threshold
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS,
    parameter int START_POS   = 0,
    parameter int END_POS     = WIDTH*HEIGHT-1,
    parameter int OFFSET_C    = 5
) (
    input  logic                            clock,
    input  logic                            not_reset,
    adaptive_threshold_if.master            bus,
    input  logic [2:0]                      global_state,
    output logic [WIDTH_BITS+HEIGHT_BITS:0] oWhiteCount,
    output logic                            finished
);
    localparam int                POS_W   = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [POS_W-1:0]  START_P = POS_W'(START_POS);
    localparam logic [POS_W-1:0]  END_P   = POS_W'(END_POS);
    localparam logic [7:0]        OFFSET  = 8'(OFFSET_C);

    at_state_t          r_state;
    at_state_t          w_next_state;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   r_wr_pos;
    logic               r_valid;
    logic [POS_W:0]     r_white;
    logic               w_issue;
    logic [POS_W-1:0]   w_rd_addr;
    logic [7:0]         w_result;

    // State register.
    always_ff @(posedge clock or negedge not_reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (!not_reset) r_state <= ST_IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state logic; a pause in RUN returns to IDLE and resumes from r_pos.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (global_state == GS_THRESHOLD) w_next_state = ST_RUN;
            ST_RUN: begin
                if (global_state != GS_THRESHOLD) w_next_state = ST_IDLE;
                else if (r_pos == END_P)          w_next_state = ST_DRAIN;
            end
            ST_DRAIN: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: a read is issued only in RUN while the phase is still ours.
    always_comb begin
        w_issue  = (r_state == ST_RUN) && (global_state == GS_THRESHOLD);
        finished = (r_state == ST_DONE);
    end

    // Read pointer: advances once per issued pixel and holds while paused.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)   r_pos <= START_P;
        else if (w_issue) r_pos <= r_pos + 1'b1;
    end

    // Write stage: tag the pixel whose read data arrives next cycle.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_valid  <= 1'b0;
            r_wr_pos <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) r_wr_pos <= r_pos;
        end
    end

    // White-pixel counter, one wider than the address so a full image fits.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)                           r_white <= '0;
        else if (r_valid && w_result == PIX_WHITE) r_white <= r_white + 1'b1;
    end

    threshold_cmp u_cmp (
        .i_pixel  (bus.iImageData),
        .i_mean   (bus.iMeanData),
        .i_offset (OFFSET),
        .o_result (w_result)
    );

    // Image and mean share one address; parked at zero outside RUN.
    assign w_rd_addr       = (r_state == ST_RUN) ? r_pos : '0;
    assign bus.oImageCol   = w_rd_addr[WIDTH_BITS-1:0];
    assign bus.oImageRow   = w_rd_addr[POS_W-1:WIDTH_BITS];
    assign bus.oMeanCol    = w_rd_addr[WIDTH_BITS-1:0];
    assign bus.oMeanRow    = w_rd_addr[POS_W-1:WIDTH_BITS];

    assign bus.oResultCol  = r_wr_pos[WIDTH_BITS-1:0];
    assign bus.oResultRow  = r_wr_pos[POS_W-1:WIDTH_BITS];
    assign bus.oResultData = r_valid ? w_result : PIX_BLACK;
    assign bus.oResultWren = r_valid;
    assign oWhiteCount     = r_white;
endmodule
